// File: rtl/csa_prefix_resolve.sv
// csa_prefix_resolve: 3-stage Kogge-Stone resolver of a 16-bit carry-save pair; `CSA_APPROX_LOWER_EN selects an OR-approximated low section.
module csa_prefix_resolve #(
  parameter int APPROX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sum,
  input  logic [15:0] in_carry,
  input  logic [3:0]  in_tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_res,
  output logic [3:0]  out_tag
);
`ifdef CSA_APPROX_LOWER_EN
  localparam bit approx = 1'b1;
`else
  localparam bit approx = 1'b0;
`endif
  localparam logic [16:0] lo_mask  = approx ? 17'((17'd1 << APPROX_BITS) - 17'd1) : '0;
  localparam logic [16:0] seed_bit = approx ? 17'(17'd1 << (APPROX_BITS - 1)) : '0;
  function automatic logic [16:0] pfx_p(input logic [16:0] p_in, input int d0, input int d1);
    logic [16:0] p;
    p = p_in;
    for (int d = d0; d <= d1; d = d * 2)
      for (int i = 16; i >= d; i--) p[i] = p[i] & p[i - d];
    return p;
  endfunction
  function automatic logic [16:0] pfx_g(input logic [16:0] g_in, input logic [16:0] p_in, input int d0, input int d1);
    logic [16:0] g, p;
    g = g_in;
    p = p_in;
    for (int d = d0; d <= d1; d = d * 2)
      for (int i = 16; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i - d]);
        p[i] = p[i] & p[i - d];
      end
    return g;
  endfunction
  logic        v1, v2, v3, adv;
  logic [16:0] x1, y1, g2, p2, h2;
  logic [16:0] px, gx, p1, g1, h1, g3;
  logic [3:0]  t1, t2, t3;
  logic [17:0] r3;
  assign adv      = ~v3 | out_ready;
  assign in_ready = adv;
  assign px = x1 ^ y1;
  assign gx = x1 & y1;
  // Low section: no propagate, only the top low bit seeds a carry upward.
  assign p1 = px & ~lo_mask;
  assign g1 = gx & (~lo_mask | seed_bit);
  assign h1 = (px & ~lo_mask) | ((x1 | y1) & lo_mask);
  assign g3 = pfx_g(g2, p2, 8, 16);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {v1, v2, v3} <= '0;
      x1 <= '0;
      y1 <= '0;
      t1 <= '0;
      g2 <= '0;
      p2 <= '0;
      h2 <= '0;
      t2 <= '0;
      r3 <= '0;
      t3 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      x1 <= {1'b0, in_sum};
      y1 <= {in_carry, 1'b0};
      t1 <= in_tag;
      g2 <= pfx_g(g1, p1, 1, 4);
      p2 <= pfx_p(p1, 1, 4);
      h2 <= h1;
      t2 <= t1;
      r3 <= {g3[16], h2 ^ {g3[15:0], 1'b0}};
      t3 <= t2;
    end
  end
  assign out_valid = v3;
  assign out_res   = r3;
  assign out_tag   = t3;
endmodule

// File: tb/tb_csa_prefix_resolve.sv
// tb_csa_prefix_resolve: directed and streaming checks of csa_prefix_resolve in either build.
module tb_csa_prefix_resolve;
  localparam int ab = 4;
`ifdef CSA_APPROX_LOWER_EN
  localparam logic [17:0] exp_dir [5] = '{18'h01236, 18'h2FFFF, 18'h10000, 18'h00018, 18'h00003};
`else
  localparam logic [17:0] exp_dir [5] = '{18'h01236, 18'h2FFFD, 18'h10000, 18'h00010, 18'h00005};
`endif
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] in_sum = '0, in_carry = '0;
  logic [3:0]  in_tag = '0, out_tag;
  logic [17:0] out_res;
  logic [21:0] exp_q [$];
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  csa_prefix_resolve #(.APPROX_BITS(ab)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [17:0] model(input logic [15:0] s, input logic [15:0] c);
    logic [17:0] x, y, lo, hi;
    logic        cin;
    x = {2'b0, s};
    y = {1'b0, c, 1'b0};
    lo = (x | y) & 18'((1 << ab) - 1);
    cin = x[ab-1] & y[ab-1];
    hi = (x >> ab) + (y >> ab) + 18'(cin);
`ifdef CSA_APPROX_LOWER_EN
    return (hi << ab) | lo;
`else
    return x + y;
`endif
  endfunction
  task automatic push(input logic [15:0] s, input logic [15:0] c, input logic [3:0] t);
    in_valid = 1'b1;
    in_sum = s;
    in_carry = c;
    in_tag = t;
    exp_q.push_back({t, model(s, c)});
  endtask
  task automatic single(input logic [15:0] s, input logic [15:0] c, input logic [3:0] t,
                        input logic [17:0] exp, input string tag);
    int n;
    out_ready = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sum = s;
    in_carry = c;
    in_tag = t;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_res"}, 32'(out_res), 32'(exp));
    chk({tag, "_tag"}, 32'(out_tag), 32'(t));
    step();
  endtask
  task automatic drain(input int want, input int budget, input string tag);
    int got;
    logic [21:0] e;
    got = 0;
    for (int c = 0; c < budget; c++) begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_res"}, 32'(out_res), 32'(e[17:0]));
        chk({tag, "_tag"}, 32'(out_tag), 32'(e[21:18]));
        got++;
      end else if (out_valid && out_ready) got++;
      step();
    end
    chk({tag, "_cnt"}, 32'(got), 32'(want));
  endtask
  initial begin
    int first, last, got;
    logic [21:0] e, held;
    logic [15:0] s, cr;
    step();
    chk("rst_rdy_during", 32'(in_ready), 32'd1);
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(out_res), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_rdy_after", 32'(in_ready), 32'd1);
    single(16'h1234, 16'h0001, 4'h5, exp_dir[0], "d0");
    single(16'hFFFF, 16'hFFFF, 4'hA, exp_dir[1], "d1_max");
    single(16'h0000, 16'h8000, 4'h3, exp_dir[2], "d2_bit16");
    single(16'h0008, 16'h0004, 4'h1, exp_dir[3], "d3");
    single(16'h0003, 16'h0001, 4'h2, exp_dir[4], "d4");
    out_ready = 1'b1;
    first = -1;
    last = -1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("b2b_res", 32'(out_res), 32'(e[17:0]));
          chk("b2b_tag", 32'(out_tag), 32'(e[21:18]));
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 20) begin
        s = 16'($urandom);
        cr = 16'($urandom);
        push(s, cr, 4'(c));
      end else in_valid = 1'b0;
      step();
    end
    chk("b2b_cnt", 32'(got), 32'd20);
    chk("b2b_rate", 32'(last - first), 32'd19);
    push(16'h00FF, 16'h0101, 4'h6);
    step();
    push(16'h8001, 16'h7FFF, 4'h7);
    step();
    push(16'hF0F0, 16'h0F0F, 4'h8);
    step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sum = 16'hDEAD;
    in_carry = 16'hBEEF;
    in_tag = 4'hF;
    e = exp_q[0];
    chk("stall_first", 32'({out_tag, out_res}), 32'(e));
    held = {out_tag, out_res};
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_rdy", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_hold", 32'({out_tag, out_res}), 32'(held));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(3, 10, "stall_drain");
    in_sum = 16'h1111;
    in_carry = 16'h2222;
    in_valid = 1'b1;
    in_tag = 4'hC;
    step();
    in_tag = 4'hD;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_res", 32'(out_res), 32'd0);
    chk("mid_rst_tag", 32'(out_tag), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mid_rst_flush", 32'(out_valid), 32'd0);
    end
    single(16'hABCD, 16'h1357, 4'h9, model(16'hABCD, 16'h1357), "post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
